// File: rtl/rv32i_bus_arbiter_if.sv
// Bus bundle between the requesting rv32i ports, the arbiter and the shared slave.
// The arbiter uses the master modport, since it masters the slave bus and answers the cores.
// The slave modport is the environment view: the cores plus the slave device.
interface rv32i_bus_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [N_MASTERS-1:0]        m_req;
    logic [N_MASTERS*ADDR_W-1:0] m_addr;
    logic [N_MASTERS-1:0]        m_wr_ena;
    logic [N_MASTERS*DATA_W-1:0] m_wr_data;
    logic [DATA_W-1:0]           m_rd_data;
    logic [N_MASTERS-1:0]        m_ack;
    logic                        m_err;
    logic [GW-1:0]               grant_id;
    logic                        s_valid;
    logic [ADDR_W-1:0]           s_addr;
    logic                        s_wr_ena;
    logic [DATA_W-1:0]           s_wr_data;
    logic                        s_ready;
    logic [DATA_W-1:0]           s_rd_data;

    modport master (
        input  m_req, m_addr, m_wr_ena, m_wr_data, s_ready, s_rd_data,
        output m_rd_data, m_ack, m_err, grant_id, s_valid, s_addr, s_wr_ena, s_wr_data
    );

    modport slave (
        output m_req, m_addr, m_wr_ena, m_wr_data, s_ready, s_rd_data,
        input  m_rd_data, m_ack, m_err, grant_id, s_valid, s_addr, s_wr_ena, s_wr_data
    );
endinterface

// File: rtl/rv32i_bus_arbiter.sv
// N-master arbiter for rv32i instr/data/DMA ports onto one valid/ready slave bus.
// One outstanding transfer (IDLE -> BUSY -> RESP), round-robin or fixed priority,
// and a BUSY timeout that completes the transfer with an error and ERR_DATA.
module rv32i_bus_arbiter #(
    parameter int                N_MASTERS = 2,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                RR_MODE   = 1,
    parameter int                TIMEOUT   = 64,
    parameter logic [DATA_W-1:0] ERR_DATA  = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                   clk,
    input  logic                   rst,
    rv32i_bus_arbiter_if.master    bus
);
    localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state, state_nxt;

    logic [GW-1:0]        grant_q;
    logic [GW-1:0]        ptr_q;
    logic [CW-1:0]        cnt_q;
    logic [ADDR_W-1:0]    s_addr_q;
    logic                 s_wr_ena_q;
    logic [DATA_W-1:0]    s_wr_data_q;
    logic [DATA_W-1:0]    rd_data_q;
    logic                 err_q;

    logic [GW-1:0]        ptr_eff;
    logic [GW-1:0]        win;
    logic                 hi_found;
    logic                 lo_found;
    logic [GW-1:0]        hi_win;
    logic [GW-1:0]        lo_win;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 sel_wr_ena;
    logic [DATA_W-1:0]    sel_wr_data;
    logic                 timeout_hit;
    logic                 s_valid;
    logic [N_MASTERS-1:0] ack;

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    assign ptr_eff     = (RR_MODE != 0) ? ptr_q : '0;

    // Winner search: first requester at or above the pointer, else first below it,
    // which is a circular scan starting at the pointer without a modulo.
    always_comb begin
        hi_found    = 1'b0;
        lo_found    = 1'b0;
        hi_win      = '0;
        lo_win      = '0;
        sel_addr    = '0;
        sel_wr_ena  = 1'b0;
        sel_wr_data = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (bus.m_req[i]) begin
                if (i >= 32'(ptr_eff)) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_win   = GW'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_win   = GW'(i);
                end
            end
        end
        win = hi_found ? hi_win : lo_win;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (win == GW'(i)) begin
                sel_addr    = bus.m_addr[i*ADDR_W +: ADDR_W];
                sel_wr_ena  = bus.m_wr_ena[i];
                sel_wr_data = bus.m_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; s_ready is only looked at in BUSY.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|bus.m_req) state_nxt = BUSY;
            BUSY:    if (bus.s_ready || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: s_valid throughout BUSY, one-hot ack to the owner in RESP.
    always_comb begin
        s_valid = 1'b0;
        ack     = '0;
        case (state)
            BUSY: s_valid = 1'b1;
            RESP: begin
                for (int unsigned i = 0; i < N_MASTERS; i++) begin
                    ack[i] = (grant_q == GW'(i));
                end
            end
            default: ;
        endcase
    end

    // Datapath: grant latch, BUSY cycle counter, response capture, RR pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            s_addr_q    <= '0;
            s_wr_ena_q  <= 1'b0;
            s_wr_data_q <= '0;
            rd_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_q <= '0;
                    if (|bus.m_req) begin
                        grant_q     <= win;
                        s_addr_q    <= sel_addr;
                        s_wr_ena_q  <= sel_wr_ena;
                        s_wr_data_q <= sel_wr_data;
                    end
                end
                BUSY: begin
                    if (bus.s_ready) begin
                        rd_data_q <= bus.s_rd_data;
                        err_q     <= 1'b0;
                    end else if (timeout_hit) begin
                        rd_data_q <= ERR_DATA;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    err_q <= 1'b0;
                    cnt_q <= '0;
                    ptr_q <= (grant_q == GW'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_valid   = s_valid;
    assign bus.m_ack     = ack;
    assign bus.m_err     = err_q;
    assign bus.m_rd_data = rd_data_q;
    assign bus.grant_id  = grant_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wr_ena  = s_wr_ena_q;
    assign bus.s_wr_data = s_wr_data_q;
endmodule

// File: tb/tb_rv32i_bus_arbiter.sv
// Bench for rv32i_bus_arbiter: a round-robin instance checked against a
// transaction-level model (pending requests per master, circular pointer), plus a
// fixed-priority instance fed the same inputs for the grant-order scenario.
module tb_rv32i_bus_arbiter;
    localparam int          N   = 2;
    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32i_bus_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus_rr ();
    rv32i_bus_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus_fp ();

    assign bus_fp.m_req     = bus_rr.m_req;
    assign bus_fp.m_addr    = bus_rr.m_addr;
    assign bus_fp.m_wr_ena  = bus_rr.m_wr_ena;
    assign bus_fp.m_wr_data = bus_rr.m_wr_data;
    assign bus_fp.s_ready   = bus_rr.s_ready;
    assign bus_fp.s_rd_data = bus_rr.s_rd_data;

    rv32i_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1),
                        .TIMEOUT(TO), .ERR_DATA(ERR))
        dut_rr (.clk(clk), .rst(rst), .bus(bus_rr.master));

    rv32i_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0),
                        .TIMEOUT(TO), .ERR_DATA(ERR))
        dut_fp (.clk(clk), .rst(rst), .bus(bus_fp.master));

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [N-1:0]  pend;
    logic [AW-1:0] p_addr [N];
    logic          p_wr   [N];
    logic [DW-1:0] p_data [N];
    int            ptr;
    logic [DW-1:0] exp_rd;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            bus_rr.m_req[i]             = pend[i];
            bus_rr.m_addr[i*AW +: AW]    = p_addr[i];
            bus_rr.m_wr_ena[i]          = p_wr[i];
            bus_rr.m_wr_data[i*DW +: DW] = p_data[i];
        end
    endtask

    task automatic new_request(input int i, input logic [AW-1:0] a, input logic w,
                               input logic [DW-1:0] d);
        pend[i]   = 1'b1;
        p_addr[i] = a;
        p_wr[i]   = w;
        p_data[i] = d;
    endtask

    function automatic int pick_winner();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        pend = '0;
        for (int i = 0; i < N; i++) begin
            p_addr[i] = '0;
            p_wr[i]   = 1'b0;
            p_data[i] = '0;
        end
        drive_inputs();
        bus_rr.s_ready   = 1'b0;
        bus_rr.s_rd_data = '0;
        ptr    = 0;
        exp_rd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One complete transfer for the model's winner; slave is ready after w wait cycles.
    task automatic run_txn(input int w, input logic [DW-1:0] rdv, input bit drop,
                           output int lat);
        int           win;
        bit           seen;
        bit           done;
        bit           exp_err;
        logic [N-1:0] exp_ack;
        lat = 0;
        win = pick_winner();
        if (win < 0) return;
        drive_inputs();
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(negedge clk);
            lat++;
            if (bus_rr.s_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                vectors++;
                if ({bus_rr.m_ack, bus_rr.m_err, bus_rr.m_rd_data} !== {2'b00, 1'b0, exp_rd}) begin
                    miscompares++;
                    $display("FAIL idle_hold: ack/err/rd_data got %h expected %h",
                             {bus_rr.m_ack, bus_rr.m_err, bus_rr.m_rd_data}, {2'b00, 1'b0, exp_rd});
                end
                bus_rr.s_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_wait: s_valid got 0 expected 1 within 4 cycles");
            return;
        end
        exp_ack      = '0;
        exp_ack[win] = 1'b1;
        for (int k = 1; k <= TO + 2; k++) begin
            vectors++;
            if ({bus_rr.s_valid, bus_rr.grant_id, bus_rr.m_ack, bus_rr.m_err} !==
                {1'b1, 1'(win), 2'b00, 1'b0}) begin
                miscompares++;
                $display("FAIL busy_ctrl k=%0d: valid/grant/ack/err got %b expected %b", k,
                         {bus_rr.s_valid, bus_rr.grant_id, bus_rr.m_ack, bus_rr.m_err},
                         {1'b1, 1'(win), 2'b00, 1'b0});
            end
            vectors++;
            if ({bus_rr.s_addr, bus_rr.s_wr_ena, bus_rr.s_wr_data} !==
                {p_addr[win], p_wr[win], p_data[win]}) begin
                miscompares++;
                $display("FAIL busy_payload k=%0d: addr/we/data got %h expected %h", k,
                         {bus_rr.s_addr, bus_rr.s_wr_ena, bus_rr.s_wr_data},
                         {p_addr[win], p_wr[win], p_data[win]});
            end
            if (drop && k == 1) begin
                pend[win] = 1'b0;
                drive_inputs();
            end
            done             = (k == w + 1) || (k == TO);
            exp_err          = (k != w + 1);
            bus_rr.s_ready   = (k == w + 1);
            bus_rr.s_rd_data = (k == w + 1) ? rdv : DW'($urandom);
            @(negedge clk);
            if (done) begin
                vectors++;
                if ({bus_rr.m_ack, bus_rr.m_err, bus_rr.s_valid} !== {exp_ack, exp_err, 1'b0}) begin
                    miscompares++;
                    $display("FAIL resp_ctrl: ack/err/valid got %b expected %b",
                             {bus_rr.m_ack, bus_rr.m_err, bus_rr.s_valid}, {exp_ack, exp_err, 1'b0});
                end
                exp_rd = exp_err ? ERR : rdv;
                vectors++;
                if (bus_rr.m_rd_data !== exp_rd) begin
                    miscompares++;
                    $display("FAIL resp_data: m_rd_data got %h expected %h", bus_rr.m_rd_data, exp_rd);
                end
                bus_rr.s_ready = 1'b0;
                pend[win] = 1'b0;
                ptr = (win + 1) % N;
                drive_inputs();
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL busy_bound: no completion got none expected by cycle %0d", TO);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({bus_rr.s_valid, bus_rr.m_ack, bus_rr.m_err, bus_rr.s_wr_ena, bus_rr.grant_id} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: valid/ack/err/we/grant got %b expected 000000",
                     {bus_rr.s_valid, bus_rr.m_ack, bus_rr.m_err, bus_rr.s_wr_ena, bus_rr.grant_id});
        end
        vectors++;
        if ({bus_rr.s_addr, bus_rr.s_wr_data, bus_rr.m_rd_data} !== 96'b0) begin
            miscompares++;
            $display("FAIL reset_data: addr/wdata/rdata got %h expected 0",
                     {bus_rr.s_addr, bus_rr.s_wr_data, bus_rr.m_rd_data});
        end
        do_reset();
    endtask

    task automatic test_single_read();
        int lat;
        new_request(0, 32'h0000_0100, 1'b0, $urandom);
        run_txn(0, 32'h1234_5678, 1'b0, lat);
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL read_latency: s_valid cycle got %0d expected 1", lat);
        end
    endtask

    task automatic test_fairness();
        int rr_seq[$];
        int fp_seq[$];
        int rr_cyc[$];
        int exp_rr[4] = '{0, 1, 0, 1};
        int exp_cyc[4] = '{2, 5, 8, 11};
        do_reset();
        for (int i = 0; i < N; i++) new_request(i, $urandom, 1'b0, $urandom);
        drive_inputs();
        bus_rr.s_ready = 1'b1;
        for (int c = 1; c <= 20 && rr_seq.size() < 4; c++) begin
            @(negedge clk);
            if (bus_rr.m_ack != 2'b00) begin
                rr_seq.push_back(bus_rr.m_ack == 2'b01 ? 0 : (bus_rr.m_ack == 2'b10 ? 1 : -1));
                rr_cyc.push_back(c);
            end
            if (bus_fp.m_ack != 2'b00)
                fp_seq.push_back(bus_fp.m_ack == 2'b01 ? 0 : (bus_fp.m_ack == 2'b10 ? 1 : -1));
        end
        pend = '0;
        drive_inputs();
        bus_rr.s_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            int g_rr, g_fp, g_cyc;
            g_rr  = (j < rr_seq.size()) ? rr_seq[j] : -9;
            g_fp  = (j < fp_seq.size()) ? fp_seq[j] : -9;
            g_cyc = (j < rr_cyc.size()) ? rr_cyc[j] : -9;
            vectors++;
            if (g_rr !== exp_rr[j]) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: grant got %0d expected %0d", j, g_rr, exp_rr[j]);
            end
            vectors++;
            if (g_fp !== 0) begin
                miscompares++;
                $display("FAIL fp_order[%0d]: grant got %0d expected 0", j, g_fp);
            end
            vectors++;
            if (g_cyc !== exp_cyc[j]) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: ack cycle got %0d expected %0d", j, g_cyc, exp_cyc[j]);
            end
        end
        do_reset();
    endtask

    task automatic test_write_wait();
        int lat;
        new_request(1, 32'h8000_0004, 1'b1, 32'h0000_00A5);
        run_txn(5, $urandom, 1'b0, lat);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({bus_rr.m_ack, bus_rr.s_valid} !== 3'b000) begin
                miscompares++;
                $display("FAIL single_ack: ack/valid got %b expected 000", {bus_rr.m_ack, bus_rr.s_valid});
            end
        end
    endtask

    task automatic test_timeout();
        int lat;
        new_request(0, $urandom, 1'b0, $urandom);
        run_txn(1000, $urandom, 1'b0, lat);
        @(negedge clk);
        vectors++;
        if ({bus_rr.m_err, bus_rr.m_rd_data} !== {1'b0, ERR}) begin
            miscompares++;
            $display("FAIL err_clear: err/rd_data got %h expected %h", {bus_rr.m_err, bus_rr.m_rd_data}, {1'b0, ERR});
        end
    endtask

    task automatic test_ready_last();
        int lat;
        new_request(1, $urandom, 1'b0, $urandom);
        run_txn(TO - 1, 32'hCAFE_F00D, 1'b0, lat);
    endtask

    task automatic test_idle_ready();
        pend = '0;
        drive_inputs();
        bus_rr.s_ready   = 1'b1;
        bus_rr.s_rd_data = $urandom;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if ({bus_rr.s_valid, bus_rr.m_ack, bus_rr.m_rd_data} !== {3'b000, exp_rd}) begin
                miscompares++;
                $display("FAIL idle_ready: valid/ack/rd_data got %h expected %h",
                         {bus_rr.s_valid, bus_rr.m_ack, bus_rr.m_rd_data}, {3'b000, exp_rd});
            end
        end
        bus_rr.s_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        int  lat;
        bit  seen;
        do_reset();
        new_request(0, $urandom, 1'b0, $urandom);
        run_txn(0, $urandom, 1'b0, lat);
        new_request(1, $urandom, 1'b1, $urandom);
        drive_inputs();
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(negedge clk);
            if (bus_rr.s_valid === 1'b1) seen = 1'b1;
        end
        vectors++;
        if ({seen, bus_rr.grant_id} !== 2'b11) begin
            miscompares++;
            $display("FAIL pre_abort_grant: seen/grant got %b expected 11", {seen, bus_rr.grant_id});
        end
        bus_rr.s_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({bus_rr.s_valid, bus_rr.m_ack, bus_rr.m_err, bus_rr.s_wr_ena, bus_rr.grant_id} !== 6'b0) begin
            miscompares++;
            $display("FAIL abort_ctrl: valid/ack/err/we/grant got %b expected 000000",
                     {bus_rr.s_valid, bus_rr.m_ack, bus_rr.m_err, bus_rr.s_wr_ena, bus_rr.grant_id});
        end
        vectors++;
        if ({bus_rr.s_addr, bus_rr.s_wr_data, bus_rr.m_rd_data} !== 96'b0) begin
            miscompares++;
            $display("FAIL abort_data: addr/wdata/rdata got %h expected 0",
                     {bus_rr.s_addr, bus_rr.s_wr_data, bus_rr.m_rd_data});
        end
        ptr    = 0;
        exp_rd = '0;
        bus_rr.s_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (bus_rr.m_ack !== 2'b00) begin
                miscompares++;
                $display("FAIL abort_no_ack: m_ack got %b expected 00", bus_rr.m_ack);
            end
        end
        bus_rr.s_ready = 1'b0;
        new_request(0, $urandom, 1'b0, $urandom);
        rst = 1'b1;
        run_txn(int'($urandom_range(0, 3)), $urandom, 1'b0, lat);
    endtask

    task automatic test_random();
        int lat;
        int r;
        int w;
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    new_request(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
            if (pend == '0)
                new_request(int'($urandom_range(0, N - 1)), $urandom, 1'($urandom_range(0, 1)), $urandom);
            r = int'($urandom_range(0, 9));
            if (r < 6)      w = int'($urandom_range(0, 3));
            else if (r < 8) w = int'($urandom_range(4, TO - 1));
            else            w = int'($urandom_range(TO, TO + 3));
            run_txn(w, $urandom, ($urandom_range(0, 3) == 0), lat);
        end
    endtask

    initial begin
        pend = '0;
        for (int i = 0; i < N; i++) begin
            p_addr[i] = '0;
            p_wr[i]   = 1'b0;
            p_data[i] = '0;
        end
        ptr    = 0;
        exp_rd = '0;
        drive_inputs();
        bus_rr.s_ready   = 1'b0;
        bus_rr.s_rd_data = '0;

        test_reset();
        test_single_read();
        test_fairness();
        test_write_wait();
        test_timeout();
        test_ready_last();
        test_idle_ready();
        test_reset_mid_busy();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: finish got not reached expected before 1ms, miscompares %0d", miscompares);
        $fatal(1, "watchdog expired");
    end
endmodule
